// File: rtl/sram_resp_pkg.sv
// Shared types and default parameters for the SRAM test-interface responder.
package sram_resp_pkg;

  typedef enum logic {INIT, READY} state_t;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam logic [7:0] INIT_PAT_DEF = 8'h00;

endpackage

// File: rtl/sram_resp_array.sv
// Inferred single-port RAM: one shared address, one write port, registered read.
module sram_resp_array
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int ARR_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [ARR_DEPTH];

  // No reset on the array or its read register so the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Target-side model of the 1K x 8 SRAM test interface with init fill,
// read-path stuck-bit fault injection and saturating access counters.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_PAT = DATA_W'(INIT_PAT_DEF),
  parameter int                CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_cen,
  input  logic              s_wen,
  input  logic              s_oen,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_ddata,
  output logic [DATA_W-1:0] s_qdata,
  input  logic              fault_en,
  input  logic [ADDR_W-1:0] fault_addr,
  input  logic [DATA_W-1:0] fault_mask,
  input  logic [DATA_W-1:0] fault_val,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              ready;
  logic              wr_acc;
  logic              rd_acc;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] raw_q;
  logic              oen_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] val_q;

  assign ready     = (state == READY);
  assign wr_acc    = ready && !s_cen && !s_wen;
  assign rd_acc    = ready && !s_cen && s_wen;
  assign arr_we    = !ready || wr_acc;
  assign arr_addr  = ready ? s_addr : ptr;
  assign arr_wdata = ready ? s_ddata : INIT_PAT;

  sram_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (rd_acc),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (raw_q)
  );

  // Fault and oen are captured alongside the read, so the raw RAM word is
  // patched after its read register and the stored word is never touched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oen_q  <= 1'b1;
      mask_q <= '0;
      val_q  <= '0;
    end else if (rd_acc) begin
      oen_q  <= s_oen;
      mask_q <= (fault_en && (s_addr == fault_addr)) ? fault_mask : '0;
      val_q  <= fault_val;
    end
  end

  assign s_qdata = oen_q ? '0 : ((raw_q & ~mask_q) | (val_q & mask_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= INIT;
      ptr     <= '0;
      busy    <= 1'b1;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == ADDR_W'(MEM_DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
          if (!s_cen && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
        READY: begin
          if (wr_acc && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
          if (rd_acc && (rd_cnt != '1)) rd_cnt <= rd_cnt + 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table plus init, reset and
// counter-saturation sequences (second small instance for saturation).
module tb_sram_responder;
  import sram_resp_pkg::*;

  typedef struct {
    logic       cen;
    logic       wen;
    logic       oen;
    logic [9:0] addr;
    logic [7:0] ddata;
    logic       fen;
    logic [9:0] faddr;
    logic [7:0] fmask;
    logic [7:0] fval;
    logic [7:0] exp_q;
    string      name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_cen = 1'b1, s_wen = 1'b1, s_oen = 1'b1;
  logic [9:0]  s_addr = '0;
  logic [7:0]  s_ddata = '0;
  logic [7:0]  s_qdata;
  logic        fault_en = 1'b0;
  logic [9:0]  fault_addr = '0;
  logic [7:0]  fault_mask = '0, fault_val = '0;
  logic        busy;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;

  logic        s2_cen = 1'b1, s2_wen = 1'b1;
  logic [1:0]  s2_addr = '0;
  logic [7:0]  s2_ddata = '0;
  logic [7:0]  s2_qdata;
  logic        s2_busy;
  logic [1:0]  s2_wr, s2_rd, s2_err;

  int total = 0;
  int bad = 0;
  int cycles;
  vec_t vecs[18];

  always #5 clk = ~clk;

  sram_responder dut (
    .clk(clk), .reset_n(reset_n),
    .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen), .s_addr(s_addr),
    .s_ddata(s_ddata), .s_qdata(s_qdata),
    .fault_en(fault_en), .fault_addr(fault_addr),
    .fault_mask(fault_mask), .fault_val(fault_val),
    .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
  );

  sram_responder #(.ADDR_W(2), .DATA_W(8), .INIT_PAT(8'h5A), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .s_cen(s2_cen), .s_wen(s2_wen), .s_oen(1'b0), .s_addr(s2_addr),
    .s_ddata(s2_ddata), .s_qdata(s2_qdata),
    .fault_en(1'b0), .fault_addr(2'b00),
    .fault_mask(8'h00), .fault_val(8'h00),
    .busy(s2_busy), .wr_cnt(s2_wr), .rd_cnt(s2_rd), .err_cnt(s2_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access cycle on the main instance, then back to idle.
  task automatic applyStimulus(input vec_t v);
    s_cen = v.cen; s_wen = v.wen; s_oen = v.oen;
    s_addr = v.addr; s_ddata = v.ddata;
    fault_en = v.fen; fault_addr = v.faddr; fault_mask = v.fmask; fault_val = v.fval;
    @(posedge clk); #1;
    s_cen = 1'b1; s_wen = 1'b1; fault_en = 1'b0;
  endtask

  task automatic applyS2(input logic wen, input logic [1:0] addr, input logic [7:0] data);
    s2_cen = 1'b0; s2_wen = wen; s2_addr = addr; s2_ddata = data;
    @(posedge clk); #1;
    s2_cen = 1'b1; s2_wen = 1'b1;
  endtask

  // Counts edges until busy falls; run 0 injects rejected accesses, run 1
  // releases dut2's held chip enable after a few cycles.
  task automatic waitBusy(input int run, output int n);
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
      s_cen = 1'b1; s_wen = 1'b1;
      if (run == 0 && (n == 100 || n == 200 || n == 300)) begin
        s_cen = 1'b0; s_wen = 1'b0; s_addr = 10'h010; s_ddata = 8'hFF;
      end
      if (run == 1 && n == 6) s2_cen = 1'b1;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'h00, "rd_000"};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'h00, "rd_3ff"};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 10'h010, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'h00, "rd_rejected_addr"};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'h055, 8'hA5, 1'b0, 10'h000, 8'h00, 8'h00, 8'h00, "wr_055_hold"};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 10'h055, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'hA5, "rd_055"};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 10'h055, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'h00, "rd_055_oen1"};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 10'h055, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'hA5, "rd_055_oen0"};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 10'h3FF, 8'h3C, 1'b0, 10'h000, 8'h00, 8'h00, 8'hA5, "wr_3ff_hold"};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'h3C, "rd_3ff_new"};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 10'h055, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'h3C, "idle_hold"};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 10'h055, 8'h00, 1'b1, 10'h055, 8'h0F, 8'h00, 8'hA0, "fault_lo"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 10'h055, 8'h00, 1'b1, 10'h055, 8'hF0, 8'h50, 8'h55, "fault_hi"};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1, 10'h055, 8'hFF, 8'hFF, 8'h3C, "fault_other_addr"};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 10'h055, 8'h00, 1'b0, 10'h055, 8'hFF, 8'hFF, 8'hA5, "fault_off"};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 10'h055, 8'h11, 1'b0, 10'h000, 8'h00, 8'h00, 8'hA5, "wen_no_cen"};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 10'h055, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'hA5, "rd_055_intact"};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 10'h000, 8'hFF, 1'b0, 10'h000, 8'h00, 8'h00, 8'hA5, "wr_000"};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'hFF, "rd_000_ff"};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_qdata", s_qdata, 0);
    checkOutput("rst_wr_cnt", wr_cnt, 0);
    checkOutput("rst_rd_cnt", rd_cnt, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    #2 reset_n = 1'b1;

    waitBusy(0, cycles);
    checkOutput("init_cycles", cycles, 1024);
    checkOutput("init_err_cnt", err_cnt, 3);
    checkOutput("init_wr_cnt", wr_cnt, 0);
    checkOutput("init_qdata", s_qdata, 0);
    checkOutput("s2_busy_done", s2_busy, 0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, s_qdata, vecs[i].exp_q);
    end
    checkOutput("tbl_wr_cnt", wr_cnt, 3);
    checkOutput("tbl_rd_cnt", rd_cnt, 13);
    checkOutput("tbl_err_cnt", err_cnt, 3);

    // Reset lands between edges of a write burst to 0x055.
    s_cen = 1'b0; s_wen = 1'b0; s_addr = 10'h055; s_ddata = 8'h77;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 1);
    checkOutput("mid_rst_wr_cnt", wr_cnt, 0);
    checkOutput("mid_rst_rd_cnt", rd_cnt, 0);
    checkOutput("mid_rst_qdata", s_qdata, 0);
    @(posedge clk); #1;
    s_cen = 1'b1; s_wen = 1'b1;
    s2_cen = 1'b0; s2_wen = 1'b1;
    #2 reset_n = 1'b1;
    waitBusy(1, cycles);
    checkOutput("refill_cycles", cycles, 1024);
    checkOutput("refill_wr_cnt", wr_cnt, 0);
    checkOutput("refill_err_cnt", err_cnt, 0);
    checkOutput("s2_err_sat", s2_err, 3);
    checkOutput("s2_rd_after_init", s2_rd, 2);
    applyStimulus('{1'b0, 1'b1, 1'b0, 10'h055, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'h00, "refill_055"});
    checkOutput("refill_055", s_qdata, 8'h00);
    applyStimulus('{1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 8'h00, 8'h00, "refill_000"});
    checkOutput("refill_000", s_qdata, 8'h00);
    checkOutput("refill_rd_cnt", rd_cnt, 2);

    // Small instance: non-zero fill pattern and counter saturation.
    applyS2(1'b1, 2'd0, 8'h00);
    checkOutput("s2_init_pat", s2_qdata, 8'h5A);
    applyS2(1'b0, 2'd1, 8'h11);
    applyS2(1'b1, 2'd1, 8'h00);
    checkOutput("s2_rd_1", s2_qdata, 8'h11);
    applyS2(1'b0, 2'd2, 8'h22);
    applyS2(1'b0, 2'd3, 8'h33);
    applyS2(1'b0, 2'd0, 8'h0F);
    applyS2(1'b1, 2'd0, 8'h00);
    checkOutput("s2_rd_0", s2_qdata, 8'h0F);
    checkOutput("s2_wr_sat", s2_wr, 3);
    checkOutput("s2_rd_sat", s2_rd, 3);
    checkOutput("s2_err_hold", s2_err, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
